axis_sample_packer: RTL and testbench
=====================================

AXIS_SAMPLE_PACKER -- requirements
Module: axis_sample_packer

Interface
REQ-001 Parameter C_S00_AXIS_TDATA_WIDTH, 32, slave AXIS data width; each beat carries one 16-bit sample in bits [15:0].
REQ-002 Parameter C_M00_AXIS_TDATA_WIDTH, 192, master AXIS data width; each beat carries 12 samples.
REQ-003 Parameter FRAME_WORDS, 64, number of 192-bit words per frame (768 samples).
REQ-004 Port s00_axis_aclk  input  1  sole clock; every register in the block is clocked on its rising edge.
REQ-005 Port s00_axis_aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 Port s00_axis_tvalid  input  1  slave beat valid.
REQ-007 Port s00_axis_tlast  input  1  slave beat is the last sample of a frame.
REQ-008 Port s00_axis_tdata  input  C_S00_AXIS_TDATA_WIDTH  sample in [15:0]; upper bits ignored.
REQ-009 Port s00_axis_tstrb  input  C_S00_AXIS_TDATA_WIDTH/8  ignored.
REQ-010 Port s00_axis_tready  output  1  slave ready.
REQ-011 Port m00_axis_tready  input  1  master ready.
REQ-012 Port m00_axis_tvalid  output  1  master beat valid.
REQ-013 Port m00_axis_tlast  output  1  last word of frame.
REQ-014 Port m00_axis_tdata  output  C_M00_AXIS_TDATA_WIDTH  12 packed samples.
REQ-015 Port m00_axis_tstrb  output  C_M00_AXIS_TDATA_WIDTH/8  constant all ones.

Function
REQ-016 States: IDLE, FILLING, DUMPING; slave handshake = s00_axis_tvalid & s00_axis_tready; master handshake = m00_axis_tvalid & m00_axis_tready.
REQ-017 s00_axis_tready shall be 1 in IDLE and FILLING, 0 in DUMPING.
REQ-018 IDLE: first slave handshake stores the sample as sample 0 and moves to FILLING.
REQ-019 Packing: sample k of a word occupies bits [16k+15:16k], k = 0..11; first-received sample in LSBs.
REQ-020 A 4-bit sample index and 6-bit word address shall track position; the 12th sample of a word writes the packed word to an internal FRAME_WORDS x 192 buffer at the word address, then index wraps to 0 and address increments.
REQ-021 Full frame: the write of word FRAME_WORDS-1 moves to DUMPING regardless of s00_axis_tlast.
REQ-022 Early end: s00_axis_tlast on a handshake before sample 767 shall zero-fill the remaining lanes of the current word, write it, record word count N = address+1, and move to DUMPING.
REQ-023 s00_axis_tlast coinciding with the 12th sample of a word shall write that word with no padding word added.
REQ-024 m00_axis_tvalid shall rise on the second rising edge after the edge performing the final buffer write (one-cycle buffer read latency).
REQ-025 DUMPING shall emit words 0..N-1 in order (N = FRAME_WORDS for full frame), one per master handshake, no bubbles while m00_axis_tready is held 1.
REQ-026 While m00_axis_tvalid=1 and m00_axis_tready=0, m00_axis_tdata and m00_axis_tlast shall hold stable.
REQ-027 m00_axis_tlast shall be 1 exactly on word N-1.
REQ-028 Handshake of word N-1 shall deassert m00_axis_tvalid on the next edge and return to IDLE; the next frame may begin on the following cycle.
REQ-029 Slave beats presented during DUMPING shall not be accepted or stored.

Reset
REQ-030 Reset low shall asynchronously force state IDLE, index 0, address 0, m00_axis_tvalid 0, m00_axis_tlast 0, m00_axis_tdata 0; buffer contents need not be cleared.
REQ-031 Reset mid-FILLING or mid-DUMPING shall discard the partial frame; after release, the next accepted sample is sample 0 of a new frame.

Verification
REQ-032 768-sample ramp 0..767, tready=1 -> 64 beats, beat 0 = samples 11..0 (MSB..LSB), beat 63 = samples 767..756, tlast only on beat 63, tvalid rises 2 cycles after last write.
REQ-033 Same frame, m00_axis_tready random 50% -> identical 64-word sequence, tdata/tlast stable on every stalled cycle.
REQ-034 13 samples 0x100..0x10C, tlast on 13th -> 2 beats; beat 1 = 0x10C in [15:0], bits [191:16] zero, tlast on beat 1.
REQ-035 Slave tvalid held 1 during DUMPING -> s00_axis_tready 0 throughout, output sequence unaffected.
REQ-036 Reset pulse during beat 30 of dump, then new 768-sample frame -> no stale words, new frame output intact.
REQ-037 Two frames back-to-back, input tvalid continuous -> second frame's sample 0 accepted the cycle after first frame's final handshake.

Source files
------------

// File: rtl/axis_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : axis_sample_packer
// Description : Packs a stream of 16-bit samples (one per slave AXIS beat)
//               into 192-bit words of 12 samples, buffers up to FRAME_WORDS
//               words of a frame, then replays the frame on the master AXIS
//               port. An early s00_axis_tlast closes the frame with the
//               current word zero-padded.
// Ports       : s00_axis_aclk     - sole clock, rising edge
//               s00_axis_aresetn  - asynchronous active-low reset
//               s00_axis_t*       - slave stream (sample in tdata[15:0])
//               m00_axis_t*       - master stream (12 packed samples/beat)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_sample_packer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 192,
  parameter int FRAME_WORDS            = 64
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  localparam int c_sample_w = 16;
  localparam int c_lanes    = C_M00_AXIS_TDATA_WIDTH / c_sample_w;
  localparam int c_addr_w   = $clog2(FRAME_WORDS);
  localparam logic [3:0]          c_last_idx  = 4'(c_lanes - 1);
  localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    DUMPING = 2'd2
  } state_t;

  state_t                              r_state;
  logic [3:0]                          r_idx;
  logic [c_addr_w-1:0]                 r_addr;
  logic [c_addr_w-1:0]                 r_final_addr;
  logic [c_addr_w-1:0]                 r_rd_ptr;
  logic                                r_primed;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   r_word;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   r_buf [FRAME_WORDS];

  logic                                w_s_hs;
  logic                                w_m_hs;
  logic                                w_word_done;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   w_sample_ext;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   w_word_next;
  logic                                w_unused;

  assign s00_axis_tready = (r_state != DUMPING);
  assign m00_axis_tstrb  = '1;

  assign w_s_hs = s00_axis_tvalid & s00_axis_tready;
  assign w_m_hs = m00_axis_tvalid & m00_axis_tready;

  // r_word holds zeros in every lane not yet written, so OR-ing the new
  // sample into lane r_idx also yields the zero-padded word on an early tlast.
  assign w_sample_ext = {{(C_M00_AXIS_TDATA_WIDTH - c_sample_w){1'b0}},
                         s00_axis_tdata[c_sample_w-1:0]};
  assign w_word_next  = r_word | (w_sample_ext << {r_idx, 4'b0000});
  assign w_word_done  = w_s_hs & ((r_idx == c_last_idx) | s00_axis_tlast);

  assign w_unused = &{1'b0, s00_axis_tstrb,
                      s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:c_sample_w]};

  // Frame buffer: contents survive reset; the FSM never reads a word that
  // was not written in the current frame.
  always_ff @(posedge s00_axis_aclk) begin
    if (w_word_done) begin
      r_buf[r_addr] <= w_word_next;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state         <= IDLE;
      r_idx           <= 4'd0;
      r_addr          <= '0;
      r_final_addr    <= '0;
      r_rd_ptr        <= '0;
      r_primed        <= 1'b0;
      r_word          <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
    end else begin
      case (r_state)
        IDLE, FILLING: begin
          if (w_s_hs) begin
            if (w_word_done) begin
              r_word <= '0;
              r_idx  <= 4'd0;
              if (s00_axis_tlast || (r_addr == c_last_addr)) begin
                r_state      <= DUMPING;
                r_final_addr <= r_addr;
                r_addr       <= '0;
                r_rd_ptr     <= '0;
                r_primed     <= 1'b0;
              end else begin
                r_addr  <= r_addr + c_addr_w'(1);
                r_state <= FILLING;
              end
            end else begin
              r_word  <= w_word_next;
              r_idx   <= r_idx + 4'd1;
              r_state <= FILLING;
            end
          end
        end

        DUMPING: begin
          if (!r_primed) begin
            // One idle cycle after the final write: first word appears on
            // the following edge, matching the buffer's read latency.
            r_primed <= 1'b1;
          end else if (w_m_hs && m00_axis_tlast) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            r_state         <= IDLE;
          end else if (!m00_axis_tvalid || w_m_hs) begin
            // Load the next word when the output register is empty or is
            // being consumed this cycle; otherwise it holds under stall.
            m00_axis_tdata  <= r_buf[r_rd_ptr];
            m00_axis_tlast  <= (r_rd_ptr == r_final_addr);
            m00_axis_tvalid <= 1'b1;
            r_rd_ptr        <= r_rd_ptr + c_addr_w'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_sample_packer
// Description : Self-checking bench for axis_sample_packer. A packing model
//               pushes expected output words to a scoreboard as samples are
//               accepted; a monitor pops and compares on each master
//               handshake and checks hold-under-stall and output latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_sample_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_tvalid;
  logic         s_tlast;
  logic [31:0]  s_tdata;
  logic [3:0]   s_tstrb;
  logic         s_tready;
  logic         m_tready;
  logic         m_tvalid;
  logic         m_tlast;
  logic [191:0] m_tdata;
  logic [23:0]  m_tstrb;

  always #5 clk = ~clk;

  axis_sample_packer #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(192),
    .FRAME_WORDS           (64)
  ) u_dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tready (s_tready),
    .m00_axis_tready (m_tready),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb)
  );

  typedef struct packed {
    logic [191:0] data;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   n_vec       = 0;
  int   n_err       = 0;
  int   n_beats     = 0;
  int   cyc         = 0;
  int   last_wr_cyc = 0;
  int   last_hs_cyc = 0;
  bit   rnd_ready   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Master ready changes just after each edge, so it is stable at sampling.
  always @(posedge clk) begin
    #2;
    m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [191:0] got,
                     input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: values seen here are those presented at
  // the next rising edge.
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic         prev_l = 1'b0;
  logic [191:0] prev_d = '0;
  exp_t         e;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (m_tvalid) begin
        chk("s_tready_in_dump", 192'(s_tready), 192'(0));
        chk("tstrb", 192'(m_tstrb), 192'(24'hFFFFFF));
        if (prev_v && !prev_r) begin
          chk("hold_tdata", m_tdata, prev_d);
          chk("hold_tlast", 192'(m_tlast), 192'(prev_l));
        end
        if (!prev_v) chk("tvalid_latency", 192'(cyc - last_wr_cyc), 192'(2));
        if (m_tready) begin
          chk("unexpected_beat", 192'(sb.size() == 0), 192'(0));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("tdata", m_tdata, e.data);
            chk("tlast", 192'(m_tlast), 192'(e.last));
          end
          n_beats++;
          if (m_tlast) last_hs_cyc = cyc + 1;
        end
      end
      prev_v = m_tvalid;
      prev_r = m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
    end
  end

  // Present one sample and hold it until accepted; acc is the accepting edge.
  task automatic send(input logic [15:0] d, input bit last, output int acc);
    int t = 0;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = {16'($urandom), d};
    s_tstrb  = 4'($urandom);
    s_tlast  = last;
    while (!s_tready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) chk("tready_timeout", 192'(s_tready), 192'(1));
    @(posedge clk);
    #1;
    acc         = cyc;
    last_wr_cyc = cyc;
  endtask

  task automatic send_frame(input int n, input logic [15:0] base,
                            input bit use_last, input bit chk_b2b);
    logic [191:0] w;
    logic [15:0]  s;
    bit           last;
    int           acc;
    exp_t         x;
    w = '0;
    for (int i = 0; i < n; i++) begin
      s    = base + 16'(i);
      last = use_last && (i == n - 1);
      w[16*(i%12) +: 16] = s;
      send(s, last, acc);
      if (chk_b2b && i == 0) chk("b2b_first_accept", 192'(acc), 192'(last_hs_cyc + 1));
      if ((i % 12 == 11) || last) begin
        x.data = w;
        x.last = (i == n - 1);
        sb.push_back(x);
        w = '0;
      end
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 192'(sb.size()), 192'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_m_tvalid", 192'(m_tvalid), 192'(0));
    chk("rst_m_tlast",  192'(m_tlast),  192'(0));
    chk("rst_m_tdata",  m_tdata,        192'(0));
    chk("rst_s_tready", 192'(s_tready), 192'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Full ramp frame, master always ready
    send_frame(768, 16'h0000, 1'b0, 1'b0);
    idle_in();
    drain();

    // Same frame with random master backpressure
    rnd_ready = 1'b1;
    send_frame(768, 16'h0000, 1'b0, 1'b0);
    idle_in();
    drain();
    rnd_ready = 1'b0;

    // Early end: 13 samples, 12 samples exactly, single sample
    send_frame(13, 16'h0100, 1'b1, 1'b0);
    idle_in();
    drain();
    send_frame(12, 16'h0200, 1'b1, 1'b0);
    idle_in();
    drain();
    send_frame(1, 16'h0300, 1'b1, 1'b0);
    idle_in();
    drain();

    // Back-to-back frames; slave valid held high through the first dump
    send_frame(768, 16'h4000, 1'b0, 1'b0);
    send_frame(768, 16'h5000, 1'b1, 1'b1);
    idle_in();
    drain();

    // Reset in the middle of a dump, then a fresh frame
    base = n_beats;
    send_frame(768, 16'h6000, 1'b0, 1'b0);
    idle_in();
    t = 0;
    while (n_beats < base + 30 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("beats_before_reset", 192'(n_beats >= base + 30), 192'(1));
    #1;
    rst_n = 1'b0;
    sb.delete();
    #2;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(768, 16'h7000, 1'b0, 1'b0);
    idle_in();
    drain();

    repeat (10) @(negedge clk);
    chk("final_scoreboard", 192'(sb.size()), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
